menu_blit: RTL and testbench
============================

MENU_BLIT -- requirements
Module: menu_blit

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning name-table width in tiles.
REQ-002 SHALL have parameter ROWS, default 30, meaning visible name-table height in tiles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle command strobe.
REQ-007 SHALL have port mode, input, 1, command type: 0 = fill with fill_val, 1 = stream from s_data.
REQ-008 SHALL have port nt_sel, input, 1, name-table select, used as RAM address bit 10.
REQ-009 SHALL have ports x and y, input, 5 each, rectangle origin in tiles.
REQ-010 SHALL have ports w and h, input, 6 each, rectangle size in tiles.
REQ-011 SHALL have port fill_val, input, 8, tile byte for fill mode.
REQ-012 SHALL have port attr, input, 4, palette/bank value written with every tile.
REQ-013 SHALL have ports s_valid (input, 1), s_data (input, 8) and s_ready (output, 1), forming the stream-mode tile source.
REQ-014 SHALL have outputs ram_we (1), ram_addr (11), ram_dat (8) and ram_atr (4), forming the write port into the name-table and attribute RAMs.
REQ-015 SHALL have outputs busy (1) and done (1); done is a one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 IDLE: start=1 SHALL latch all command inputs, zero the column and row counters, and enter RUN on the next cycle.
REQ-018 IDLE: start with w=0 or h=0 SHALL go directly to DONE with no writes.
REQ-019 start while busy=1 SHALL be ignored; the latched command SHALL be unaffected.
REQ-020 Tile position SHALL be computed as col = x + cnt_c and row = y + cnt_r, using 7-bit unsigned arithmetic with no wrap.
REQ-021 ram_addr SHALL be {nt_sel_latched, row[4:0], col[4:0]}.
REQ-022 A tile is in-bounds when col < COLS and row < ROWS.
REQ-023 RUN, fill mode: SHALL process one tile per cycle.
REQ-024 RUN, stream mode: SHALL process one tile per cycle in which s_valid & s_ready are both 1; no progress otherwise.
REQ-025 s_ready SHALL be 1 only in RUN with mode=1; it SHALL be 0 in all other states and after reset.
REQ-026 Each processed in-bounds tile SHALL assert ram_we for exactly one cycle, with ram_dat = tile byte and ram_atr = latched attr.
REQ-027 Each processed out-of-bounds tile (clipped) SHALL be consumed (counters advance, stream byte accepted) with ram_we=0.
REQ-028 ram_we, ram_addr, ram_dat and ram_atr SHALL be registered: one cycle after the tile is processed, combinational-free.
REQ-029 Counter order SHALL be row-major: cnt_c increments; at cnt_c = w-1 it resets to 0 and cnt_r increments.
REQ-030 Processing the tile with cnt_c = w-1 and cnt_r = h-1 SHALL enter DONE.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 The final ram_we pulse SHALL occur in the same cycle as done.
REQ-033 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-034 Total writes per command SHALL equal the in-bounds tile count; total stream bytes accepted SHALL equal w*h regardless of clipping.
REQ-035 s_data SHALL be ignored in fill mode, and fill_val SHALL be ignored in stream mode.

Reset
REQ-036 rst=1 SHALL, asynchronously and at any time including mid-RUN, force state IDLE, clear both counters, and drive busy=0, done=0, s_ready=0, ram_we=0, ram_addr=0, ram_dat=0, ram_atr=0.
REQ-037 An interrupted command SHALL NOT resume after reset; the next start SHALL begin a fresh command.

Verification
REQ-038 Fill: mode=0, nt_sel=0, x=2, y=3, w=4, h=2, fill_val=0x41, attr=0x5 -> 8 writes at addresses 0x062..0x065 then 0x082..0x085, all with data 0x41 and atr 0x5; done on write 8; busy high for 9 cycles.
REQ-039 Stream with stalls: mode=1, x=0, y=0, w=3, h=1, bytes 0x10, 0x11, 0x12 with s_valid low for 2 cycles between bytes -> writes at 0x000, 0x001, 0x002 in byte order; no ram_we during stalls.
REQ-040 Clip: mode=0, x=30, y=29, w=4, h=2 -> only 2 writes, at addresses 0x3BE and 0x3BF; 8 tiles consumed; done asserted.
REQ-041 Zero size: w=0, h=5 -> done one cycle after start; no ram_we.
REQ-042 Start while busy: a second start during RUN of REQ-038 -> ignored; exactly 8 writes result.
REQ-043 Reset mid-op: rst pulsed after the 3rd write of REQ-038 -> all outputs 0 immediately; a following start with w=1, h=1 gives exactly 1 write.

Source files
------------

// File: rtl/menu_blit_if.sv
// ============================================================================
// Module : menu_blit_if
// Brief  : Command, stream-source and RAM write-port bundle for menu_blit
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface menu_blit_if;
  logic        start;
  logic        mode;
  logic        nt_sel;
  logic [4:0]  x;
  logic [4:0]  y;
  logic [5:0]  w;
  logic [5:0]  h;
  logic [7:0]  fill_val;
  logic [3:0]  attr;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;

  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_dat;
  logic [3:0]  ram_atr;

  logic        busy;
  logic        done;

  // Command issuer / tile source / RAM observer side
  modport master (
    output start, mode, nt_sel, x, y, w, h, fill_val, attr,
    output s_valid, s_data,
    input  s_ready,
    input  ram_we, ram_addr, ram_dat, ram_atr,
    input  busy, done
  );

  // Blitter side
  modport slave (
    input  start, mode, nt_sel, x, y, w, h, fill_val, attr,
    input  s_valid, s_data,
    output s_ready,
    output ram_we, ram_addr, ram_dat, ram_atr,
    output busy, done
  );
endinterface

`default_nettype wire

// File: rtl/menu_blit.sv
// ============================================================================
// Module : menu_blit
// Brief  : Rectangle fill/stream blitter into name-table + attribute RAMs
// Rev    : 1.0
// ============================================================================
`default_nettype none

module menu_blit #(
  parameter int COLS = 32,
  parameter int ROWS = 30
) (
  input  wire logic   clk,
  input  wire logic   rst,
  menu_blit_if.slave  bus
);

  localparam logic [6:0] c_COLS = 7'(COLS);
  localparam logic [6:0] c_ROWS = 7'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_mode;
  logic        r_nt_sel;
  logic [4:0]  r_x;
  logic [4:0]  r_y;
  logic [5:0]  r_w;
  logic [5:0]  r_h;
  logic [7:0]  r_fill;
  logic [3:0]  r_attr;
  logic [5:0]  r_cnt_c;
  logic [5:0]  r_cnt_r;

  logic        r_ram_we;
  logic [10:0] r_ram_addr;
  logic [7:0]  r_ram_dat;
  logic [3:0]  r_ram_atr;

  logic [6:0]  w_col;
  logic [6:0]  w_row;
  logic        w_in_bounds;
  logic        w_fire;
  logic        w_last_c;
  logic        w_last;
  logic        w_zero;
  logic [7:0]  w_tile;
  logic        w_busy;
  logic        w_done;
  logic        w_s_ready;

  // 7-bit position cannot wrap: max 31 + 62 = 93
  assign w_col       = {2'b00, r_x} + {1'b0, r_cnt_c};
  assign w_row       = {2'b00, r_y} + {1'b0, r_cnt_r};
  assign w_in_bounds = (w_col < c_COLS) && (w_row < c_ROWS);
  assign w_fire      = (r_state == S_RUN) && (!r_mode || bus.s_valid);
  assign w_last_c    = (r_cnt_c == (r_w - 6'd1));
  assign w_last      = w_last_c && (r_cnt_r == (r_h - 6'd1));
  assign w_zero      = (bus.w == 6'd0) || (bus.h == 6'd0);
  assign w_tile      = r_mode ? bus.s_data : r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_s_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = w_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy    = 1'b1;
        w_s_ready = r_mode;
        if (w_fire && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch and row-major tile counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode   <= 1'b0;
      r_nt_sel <= 1'b0;
      r_x      <= 5'd0;
      r_y      <= 5'd0;
      r_w      <= 6'd0;
      r_h      <= 6'd0;
      r_fill   <= 8'd0;
      r_attr   <= 4'd0;
      r_cnt_c  <= 6'd0;
      r_cnt_r  <= 6'd0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_mode   <= bus.mode;
      r_nt_sel <= bus.nt_sel;
      r_x      <= bus.x;
      r_y      <= bus.y;
      r_w      <= bus.w;
      r_h      <= bus.h;
      r_fill   <= bus.fill_val;
      r_attr   <= bus.attr;
      r_cnt_c  <= 6'd0;
      r_cnt_r  <= 6'd0;
    end else if (w_fire) begin
      if (w_last_c) begin
        r_cnt_c <= 6'd0;
        r_cnt_r <= r_cnt_r + 6'd1;
      end else begin
        r_cnt_c <= r_cnt_c + 6'd1;
      end
    end
  end

  // Write port lags the processed tile by one cycle; clipped tiles never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= 11'd0;
      r_ram_dat  <= 8'd0;
      r_ram_atr  <= 4'd0;
    end else begin
      r_ram_we <= w_fire && w_in_bounds;
      if (w_fire && w_in_bounds) begin
        r_ram_addr <= {r_nt_sel, w_row[4:0], w_col[4:0]};
        r_ram_dat  <= w_tile;
        r_ram_atr  <= r_attr;
      end
    end
  end

  assign bus.ram_we   = r_ram_we;
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_dat  = r_ram_dat;
  assign bus.ram_atr  = r_ram_atr;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.s_ready  = w_s_ready;

endmodule

`default_nettype wire

// File: tb/tb_menu_blit.sv
// ============================================================================
// Module : tb_menu_blit
// Brief  : Randomized self-checking bench for menu_blit against a tile model
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_menu_blit;

  localparam int COLS = 32;
  localparam int ROWS = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  menu_blit_if bus();

  menu_blit #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [22:0] exp_q[$];
  logic [22:0] got_q[$];
  logic [7:0]  bytes_q[$];
  int          n_acc;
  int          n_busy;
  int          done_cyc;
  bit          timed_out;
  bit          we_at_done;
  bit          busy_after;
  bit          done_after;
  bit          last_inb;
  logic [26:0] rst_snap;

  // Reference: walk the rectangle row-major, keep only tiles inside the visible table
  task automatic build_model(input bit md, input bit nt, input int x, input int y,
                             input int w, input int h, input logic [7:0] fill,
                             input logic [3:0] attr);
    int col;
    int row;
    bit inb;
    logic [10:0] a;
    exp_q.delete();
    bytes_q.delete();
    last_inb = 1'b0;
    for (int k = 0; k < w * h; k++) bytes_q.push_back(8'($urandom));
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        col = x + c;
        row = y + r;
        inb = (col < COLS) && (row < ROWS);
        if (inb) begin
          a = {nt, 5'(row), 5'(col)};
          exp_q.push_back({a, (md ? bytes_q[r * w + c] : fill), attr});
        end
        last_inb = inb;
      end
    end
  endtask

  // Issue one command, drive the stream source and record what the DUT does
  task automatic run_cmd(input bit md, input bit nt, input int x, input int y,
                         input int w, input int h, input logic [7:0] fill,
                         input logic [3:0] attr, input int gap_fixed,
                         input int restart_at, input int rst_after);
    int idx;
    int gap;
    int budget;
    bit hit_rst;
    idx = 0; gap = 0; hit_rst = 1'b0;
    build_model(md, nt, x, y, w, h, fill, attr);
    got_q.delete();
    n_acc = 0; n_busy = 0; done_cyc = -1; timed_out = 1'b0; we_at_done = 1'b0;
    busy_after = 1'b1; done_after = 1'b1;
    budget = 16 * w * h + 40;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mode = md; bus.nt_sel = nt;
    bus.x = 5'(x); bus.y = 5'(y); bus.w = 6'(w); bus.h = 6'(h);
    bus.fill_val = fill; bus.attr = attr; bus.s_valid = 1'b0;
    @(posedge clk); #1;
    // Scramble command inputs: the latched copy must be what is used
    bus.mode = 1'($urandom); bus.nt_sel = 1'($urandom);
    bus.x = 5'($urandom); bus.y = 5'($urandom);
    bus.w = 6'($urandom); bus.h = 6'($urandom);
    bus.fill_val = 8'($urandom); bus.attr = 4'($urandom);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      bus.start = (cyc == restart_at);
      if (md) begin
        if (gap > 0) begin
          bus.s_valid = 1'b0;
          bus.s_data  = 8'($urandom);
          gap--;
        end else if (idx < w * h) begin
          bus.s_valid = (gap_fixed >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
          bus.s_data  = bus.s_valid ? bytes_q[idx] : 8'($urandom);
        end else begin
          bus.s_valid = 1'b0;
        end
      end else begin
        bus.s_valid = 1'($urandom);
        bus.s_data  = 8'($urandom);
      end
      @(negedge clk);
      if (bus.busy) n_busy++;
      if (bus.ram_we) got_q.push_back({bus.ram_addr, bus.ram_dat, bus.ram_atr});
      if (bus.s_valid && bus.s_ready) begin
        n_acc++;
        idx++;
        if (gap_fixed > 0) gap = gap_fixed;
      end
      if (rst_after >= 0 && got_q.size() == rst_after) begin
        rst = 1'b1;
        #1;
        rst_snap = {bus.busy, bus.done, bus.s_ready, bus.ram_we,
                    bus.ram_addr, bus.ram_dat, bus.ram_atr};
        @(posedge clk); #1;
        rst = 1'b0;
        hit_rst = 1'b1;
        break;
      end
      if (bus.done) begin
        done_cyc   = cyc;
        we_at_done = bus.ram_we;
        @(negedge clk);
        busy_after = bus.busy;
        done_after = bus.done;
        break;
      end
      @(posedge clk); #1;
    end
    if (done_cyc < 0 && !hit_rst) timed_out = 1'b1;
    bus.start = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.s_ready, bus.ram_we, bus.ram_addr, bus.ram_dat, bus.ram_atr} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b s_ready=%b we=%b addr=%h dat=%h atr=%h, expected all 0",
               bus.busy, bus.done, bus.s_ready, bus.ram_we, bus.ram_addr, bus.ram_dat, bus.ram_atr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    run_cmd(1'b0, 1'b0, 2, 3, 4, 2, 8'h41, 4'h5, -1, -1, -1);
    n_vec++;
    if (got_q.size() !== 8) begin
      n_err++; $display("FAIL fill_count: got %0d writes, expected 8", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fill_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (got_q.size() > 0 && got_q[0][22:12] !== 11'h062) begin
      n_err++; $display("FAIL fill_first_addr: got %h expected 062", got_q[0][22:12]);
    end
    n_vec++;
    if (done_cyc !== 9 || n_busy !== 9) begin
      n_err++; $display("FAIL fill_timing: done at cycle %0d busy %0d cycles, expected 9 and 9", done_cyc, n_busy);
    end
    n_vec++;
    if (we_at_done !== 1'b1 || busy_after !== 1'b0 || done_after !== 1'b0) begin
      n_err++; $display("FAIL fill_done_pulse: we@done=%b busy_after=%b done_after=%b, expected 1 0 0",
                        we_at_done, busy_after, done_after);
    end
    n_vec++;
    if (n_acc !== 0) begin
      n_err++; $display("FAIL fill_no_stream: got %0d stream accepts, expected 0", n_acc);
    end
  endtask

  task automatic test_stream_stall();
    bytes_q.delete();
    run_cmd(1'b1, 1'b0, 0, 0, 3, 1, 8'($urandom), 4'($urandom), 2, -1, -1);
    n_vec++;
    if (got_q.size() !== 3 || n_acc !== 3) begin
      n_err++; $display("FAIL stream_count: got %0d writes %0d accepts, expected 3 and 3", got_q.size(), n_acc);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i] || got_q[i][22:12] !== 11'(i)) begin
        n_err++; $display("FAIL stream_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (we_at_done !== 1'b1 || timed_out) begin
      n_err++; $display("FAIL stream_done: we@done=%b timeout=%b, expected 1 0", we_at_done, timed_out);
    end
  endtask

  task automatic test_clip();
    run_cmd(1'b0, 1'b0, 30, 29, 4, 2, 8'($urandom), 4'($urandom), -1, -1, -1);
    n_vec++;
    if (got_q.size() !== 2) begin
      n_err++; $display("FAIL clip_count: got %0d writes, expected 2", got_q.size());
    end else begin
      n_vec++;
      if (got_q[0][22:12] !== 11'h3BE || got_q[1][22:12] !== 11'h3BF || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
        n_err++; $display("FAIL clip_writes: got %h %h expected %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
      end
    end
    n_vec++;
    if (done_cyc !== 9 || we_at_done !== 1'b0) begin
      n_err++; $display("FAIL clip_done: done at cycle %0d we@done=%b, expected 9 and 0", done_cyc, we_at_done);
    end
  endtask

  task automatic test_zero_size();
    run_cmd(1'b0, 1'b1, 4, 4, 0, 5, 8'($urandom), 4'($urandom), -1, -1, -1);
    n_vec++;
    if (done_cyc !== 1 || got_q.size() !== 0 || n_busy !== 1) begin
      n_err++; $display("FAIL zero_size: done at cycle %0d, %0d writes, busy %0d, expected 1 0 1",
                        done_cyc, got_q.size(), n_busy);
    end
  endtask

  task automatic test_start_while_busy();
    run_cmd(1'b0, 1'b0, 2, 3, 4, 2, 8'h41, 4'h5, -1, 3, -1);
    n_vec++;
    if (got_q.size() !== 8 || done_cyc !== 9) begin
      n_err++; $display("FAIL busy_start_count: got %0d writes done at %0d, expected 8 at 9", got_q.size(), done_cyc);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL busy_start_write[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL busy_start_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int bx;
    int by;
    run_cmd(1'b0, 1'b0, 2, 3, 4, 2, 8'h41, 4'h5, -1, -1, 3);
    n_vec++;
    if (rst_snap !== 27'd0) begin
      n_err++; $display("FAIL midrst_outputs: got %h expected 0", rst_snap);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0) begin
        n_err++; $display("FAIL midrst_no_resume: got busy=%b we=%b expected 0 0", bus.busy, bus.ram_we);
      end
    end
    bx = $urandom_range(0, COLS - 1);
    by = $urandom_range(0, ROWS - 1);
    run_cmd(1'b0, 1'($urandom), bx, by, 1, 1, 8'($urandom), 4'($urandom), -1, -1, -1);
    n_vec++;
    if (got_q.size() !== 1 || done_cyc !== 2) begin
      n_err++; $display("FAIL midrst_fresh: got %0d writes done at %0d, expected 1 at 2", got_q.size(), done_cyc);
    end else begin
      n_vec++;
      if (got_q[0] !== exp_q[0]) begin
        n_err++; $display("FAIL midrst_fresh_write: got %h expected %h", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random();
    bit md;
    int w;
    int h;
    for (int t = 0; t < 16; t++) begin
      md = 1'($urandom);
      w  = $urandom_range(0, 10);
      h  = $urandom_range(0, 8);
      run_cmd(md, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), w, h,
              8'($urandom), 4'($urandom), -1, -1, -1);
      n_vec++;
      if (timed_out || got_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_count: got %0d writes timeout=%b, expected %0d", t, got_q.size(), timed_out, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (got_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL rand%0d_write[%0d]: got %h expected %h", t, i, got_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if (n_acc !== (md ? w * h : 0)) begin
        n_err++; $display("FAIL rand%0d_accepts: got %0d expected %0d", t, n_acc, md ? w * h : 0);
      end
      n_vec++;
      if (we_at_done !== last_inb) begin
        n_err++; $display("FAIL rand%0d_we_at_done: got %b expected %b", t, we_at_done, last_inb);
      end
      if (!md) begin
        n_vec++;
        if (done_cyc !== ((w * h == 0) ? 1 : w * h + 1)) begin
          n_err++; $display("FAIL rand%0d_fill_latency: got %0d expected %0d", t, done_cyc, (w * h == 0) ? 1 : w * h + 1);
        end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.nt_sel = 1'b0;
    bus.x = 5'd0; bus.y = 5'd0; bus.w = 6'd0; bus.h = 6'd0;
    bus.fill_val = 8'd0; bus.attr = 4'd0;
    bus.s_valid = 1'b0; bus.s_data = 8'd0;
    #1 rst = 1'b1;
    test_reset();
    test_fill();
    test_stream_stall();
    test_clip();
    test_zero_size();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
